vram_ctrl: RTL

Controller and arbiter for the single-port display VRAM. It parses the SPI byte stream into addressed write bursts and buffers the writes in a small FIFO. It shares the one memory port between those writes and the VGA scan-out reads, with VGA always winning. It sits between the SPI slave (`rx_data`/`rx_valid`) and the VRAM array, and presents a fixed-latency read port to the VGA timing block.

---
 rtl/vram_ctrl_pkg.sv | 14 +
 rtl/vram_wr_fifo.sv | 55 +++++
 rtl/vram_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vram_ctrl_pkg.sv
// Shared constants and types for the VRAM controller: the burst sync byte
// and the SPI parser states.
package vram_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_HI = 2'd1,
        ADDR_LO = 2'd2,
        DATA    = 2'd3
    } parse_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous write buffer holding {address, data} entries between the
// SPI parser and the memory arbiter. Push while full is accepted only with a pop.
module vram_wr_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[PW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/vram_ctrl.sv
// SPI-to-VRAM write burst parser plus single-port arbiter; VGA reads always
// win the memory port and buffered writes fill the idle cycles.
module vram_ctrl
    import vram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cs_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_vga_req,
    input  logic [ADDR_WIDTH-1:0] i_vga_addr,
    output logic [DATA_WIDTH-1:0] o_vga_data,
    output logic                  o_vga_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_frame_ready,
    output logic                  o_overflow
);

    localparam int FW   = ADDR_WIDTH + DATA_WIDTH;
    localparam int HI_W = ADDR_WIDTH - 8;

    parse_state_e          r_state;
    parse_state_e          w_state_rx;
    parse_state_e          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  r_got_byte;
    logic                  w_got_nxt;
    logic                  w_data_byte;

    logic                  r_cs_meta;
    logic                  r_cs_sync;
    logic                  r_cs_prev;
    logic                  w_cs_rise;

    logic [FW-1:0]         w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rd_issued;
    logic                  r_vga_valid;
    logic                  r_frame_ready;
    logic                  r_overflow;

    // Chip-select synchronizer and rising-edge detector, idle-high from reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
            r_cs_prev <= 1'b1;
        end else begin
            r_cs_meta <= i_cs_n;
            r_cs_sync <= r_cs_meta;
            r_cs_prev <= r_cs_sync;
        end
    end

    assign w_cs_rise = r_cs_sync & ~r_cs_prev;

    // Parser next state: the byte is handled under the old state, then a
    // chip-select release overrides the resulting state.
    always_comb begin
        w_state_rx  = r_state;
        w_ptr_nxt   = r_ptr;
        w_got_nxt   = r_got_byte;
        w_data_byte = 1'b0;
        if (i_rx_valid) begin
            case (r_state)
                IDLE: begin
                    if (i_rx_data == SYNC_BYTE) begin
                        w_state_rx = ADDR_HI;
                    end else begin
                        w_state_rx = IDLE;
                    end
                end
                ADDR_HI: begin
                    w_ptr_nxt  = {i_rx_data[HI_W-1:0], r_ptr[7:0]};
                    w_state_rx = ADDR_LO;
                end
                ADDR_LO: begin
                    w_ptr_nxt  = {r_ptr[ADDR_WIDTH-1:8], i_rx_data};
                    w_got_nxt  = 1'b0;
                    w_state_rx = DATA;
                end
                DATA: begin
                    w_data_byte = 1'b1;
                    w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
                    w_got_nxt   = 1'b1;
                    w_state_rx  = DATA;
                end
                default: begin
                    w_state_rx = IDLE;
                end
            endcase
        end else begin
            w_state_rx = r_state;
        end
        w_state_nxt = w_cs_rise ? IDLE : w_state_rx;
    end

    // Parser state, address pointer and burst-has-data flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_got_byte <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_got_byte <= w_got_nxt;
        end
    end

    assign w_pop = ~i_vga_req & ~w_fifo_empty;

    vram_wr_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_data_byte),
        .i_wdata ({r_ptr, i_rx_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Memory port arbiter: VGA read first, else drain one buffered write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_issued <= 1'b0;
            r_vga_valid <= 1'b0;
        end else begin
            if (i_vga_req) begin
                r_mem_addr <= i_vga_addr;
                r_mem_we   <= 1'b0;
            end else if (w_pop) begin
                r_mem_addr  <= w_fifo_head[FW-1:DATA_WIDTH];
                r_mem_wdata <= w_fifo_head[DATA_WIDTH-1:0];
                r_mem_we    <= 1'b1;
            end else begin
                r_mem_we <= 1'b0;
            end
            r_rd_issued <= i_vga_req;
            r_vga_valid <= r_rd_issued;
        end
    end

    // Sticky status: burst completed with data, and data lost to a full buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_ready <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_ready <= r_frame_ready |
                             (w_cs_rise & (r_state == DATA) & (r_got_byte | w_data_byte));
            r_overflow    <= r_overflow | (w_data_byte & w_fifo_full & ~w_pop);
        end
    end

    assign o_vga_data    = i_mem_rdata;
    assign o_vga_valid   = r_vga_valid;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_we      = r_mem_we;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_frame_ready = r_frame_ready;
    assign o_overflow    = r_overflow;

endmodule
